// File: rtl/conv11_fifo_sched.sv
// rtl/conv11_fifo_sched.sv - conv11 feature FIFO write/read sequencer with end-of-tile flush
// Optional stall counter output enabled by CONV11_SCHED_STALL_CNT_EN.
module conv11_fifo_sched #(
  parameter int ADDR_BITS = 10,
  parameter int ROW_BITS  = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_BITS:0]   cfg_row_words,
  input  logic [ROW_BITS-1:0]  cfg_rows,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 wr_en,
  input  logic                 out_ready,
  output logic                 rd_en,
  output logic                 dout_valid,
  output logic [ADDR_BITS:0]   M_count,
  output logic [ADDR_BITS:0]   S_count,
  input  logic                 M_Ready,
  input  logic                 S_Ready,
  output logic                 Next_Reg,
  output logic                 busy,
  output logic                 done
`ifdef CONV11_SCHED_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  localparam int CW = ADDR_BITS + 1;

  typedef enum logic {W_IDLE, W_RUN} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_READ, R_GAP} rstate_t;

  wstate_t             wstate_q, wstate_d;
  rstate_t             rstate_q, rstate_d;
  logic [CW-1:0]       row_words_q, row_words_d;
  logic [ROW_BITS-1:0] rows_q, rows_d;
  logic [CW-1:0]       wr_word_q, wr_word_d;
  logic [ROW_BITS-1:0] wr_row_q, wr_row_d;
  logic [CW-1:0]       rd_word_q, rd_word_d;
  logic [ROW_BITS-1:0] rd_row_q, rd_row_d;
  logic                gap_q, gap_d;
  logic                busy_q, busy_d;
  logic                next_reg_q, next_reg_d;
  logic                dout_valid_q, dout_valid_d;
  logic [ROW_BITS-1:0] wr_row_inc;
  logic [ROW_BITS-1:0] rd_row_inc;
  logic                start_acc;

  assign in_ready   = (wstate_q == W_RUN) & S_Ready;
  assign wr_en      = in_valid & in_ready;
  assign rd_en      = (rstate_q == R_READ) & out_ready;
  assign start_acc  = start & ~busy_q;
  assign wr_row_inc = wr_row_q + ROW_BITS'(1);
  assign rd_row_inc = rd_row_q + ROW_BITS'(1);

  assign M_count    = row_words_q;
  assign S_count    = row_words_q >> 2;
  assign dout_valid = dout_valid_q;
  assign Next_Reg   = next_reg_q;
  assign done       = next_reg_q;
  assign busy       = busy_q;

  always_comb begin
    wstate_d     = wstate_q;
    rstate_d     = rstate_q;
    row_words_d  = row_words_q;
    rows_d       = rows_q;
    wr_word_d    = wr_word_q;
    wr_row_d     = wr_row_q;
    rd_word_d    = rd_word_q;
    rd_row_d     = rd_row_q;
    gap_d        = gap_q;
    busy_d       = busy_q;
    next_reg_d   = 1'b0;
    dout_valid_d = rd_en;

    if (start_acc) begin
      row_words_d = cfg_row_words;
      rows_d      = cfg_rows;
      busy_d      = 1'b1;
      wr_word_d   = '0;
      wr_row_d    = '0;
      rd_word_d   = '0;
      rd_row_d    = '0;
      gap_d       = 1'b0;
      // An empty tile skips both sub-FSMs and flushes straight away.
      if (cfg_rows == '0) begin
        next_reg_d = 1'b1;
      end else begin
        wstate_d = W_RUN;
        rstate_d = R_WAIT;
      end
    end else begin
      if (next_reg_q) busy_d = 1'b0;

      if (wr_en) begin
        if (wr_word_q == row_words_q - CW'(1)) begin
          wr_word_d = '0;
          wr_row_d  = wr_row_inc;
          if (wr_row_inc == rows_q) wstate_d = W_IDLE;
        end else begin
          wr_word_d = wr_word_q + CW'(1);
        end
      end

      case (rstate_q)
        R_WAIT: if (M_Ready) rstate_d = R_READ;
        R_READ: begin
          if (rd_en) begin
            if (rd_word_q == (row_words_q >> 2) - CW'(1)) begin
              rd_word_d = '0;
              rd_row_d  = rd_row_inc;
              gap_d     = 1'b0;
              rstate_d  = R_GAP;
            end else begin
              rd_word_d = rd_word_q + CW'(1);
            end
          end
        end
        R_GAP: begin
          // Two gap cycles let M_Ready catch up with the row just drained.
          gap_d = 1'b1;
          if (gap_q) begin
            if (rd_row_q == rows_q) begin
              rstate_d   = R_IDLE;
              next_reg_d = 1'b1;
            end else begin
              rstate_d = R_WAIT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q     <= W_IDLE;
      rstate_q     <= R_IDLE;
      row_words_q  <= '0;
      rows_q       <= '0;
      wr_word_q    <= '0;
      wr_row_q     <= '0;
      rd_word_q    <= '0;
      rd_row_q     <= '0;
      gap_q        <= 1'b0;
      busy_q       <= 1'b0;
      next_reg_q   <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      wstate_q     <= wstate_d;
      rstate_q     <= rstate_d;
      row_words_q  <= row_words_d;
      rows_q       <= rows_d;
      wr_word_q    <= wr_word_d;
      wr_row_q     <= wr_row_d;
      rd_word_q    <= rd_word_d;
      rd_row_q     <= rd_row_d;
      gap_q        <= gap_d;
      busy_q       <= busy_d;
      next_reg_q   <= next_reg_d;
      dout_valid_q <= dout_valid_d;
    end
  end

`ifdef CONV11_SCHED_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = '0;
    end else if (((rstate_q == R_WAIT) || ((rstate_q == R_READ) && !out_ready))
                 && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule
